div_ratio_ctrl: RTL and testbench
=================================

DIV_RATIO_CTRL -- requirements
Module: div_ratio_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 4: width of the divider counter and ratio.
REQ-002 SHALL have parameter RESET_RATIO, default 8: active divide ratio after reset; legal range 2..2^CNT_W-1.
REQ-003 SHALL have parameter SETTLE_TC, default 4: terminal counts after a ratio change before settled asserts; range 1..255.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-high (1 = reset), despite the name.
REQ-006 SHALL have port en  input  1  run enable for the divider.
REQ-007 SHALL have port cfg_valid  input  1  new ratio request.
REQ-008 SHALL have port cfg_ratio  input  CNT_W  requested divide ratio N.
REQ-009 SHALL have port cfg_ready  output  1  controller can accept a ratio.
REQ-010 SHALL have port cfg_err  output  1  one-cycle pulse; accepted ratio was illegal.
REQ-011 SHALL have port cnt  output  CNT_W  current divider count.
REQ-012 SHALL have port tc  output  1  terminal-count flag, high while cnt == N-1 in RUN or PEND.
REQ-013 SHALL have port div_out  output  1  registered divided clock.
REQ-014 SHALL have port busy  output  1  ratio change pending.
REQ-015 SHALL have port settled  output  1  divider stable at active ratio.

Function
REQ-016 SHALL implement states IDLE, RUN and PEND; N denotes the active ratio register.
REQ-017 IDLE: cnt = 0, div_out = 0, tc = 0; en = 1 moves to RUN next cycle.
REQ-018 RUN/PEND: cnt increments by 1 each cycle and wraps from N-1 to 0; no other wrap value.
REQ-019 div_out SHALL be registered and equal 1 exactly when the next-cycle cnt < (N >> 1); for N = 3 the pattern is high 1 cycle, low 2 cycles.
REQ-020 cfg_ready = 1 in IDLE and RUN, 0 in PEND; a transfer occurs when cfg_valid and cfg_ready are both high on a rising edge.
REQ-021 Accepted cfg_ratio < 2: ratio dropped, state unchanged, cfg_err = 1 for the following cycle only.
REQ-022 Legal transfer in IDLE: N updates next cycle and the state stays IDLE.
REQ-023 Legal transfer in RUN: the ratio is stored in a pending register, the state moves to PEND and busy = 1.
REQ-024 PEND: on the cycle where tc = 1, cnt wraps to 0, N loads the pending ratio and the state returns to RUN.
REQ-025 PEND: busy clears in the cycle cnt becomes 0, so the first new period starts glitch-free at cnt = 0.
REQ-026 A transfer on the same cycle as tc in RUN SHALL NOT apply at that tc; it applies at the next tc.
REQ-027 en = 0 in RUN or PEND: next state IDLE with cnt = 0 and div_out = 0; any pending ratio loads into N at once and busy clears.
REQ-028 Settle counter: cleared whenever N changes or the state enters IDLE; increments on each tc pulse; saturates at SETTLE_TC.
REQ-029 settled = 1 exactly when the settle counter equals SETTLE_TC and the state is RUN.
REQ-030 A ratio request equal to the current N still completes the handshake and restarts the settle counter when it is applied.

Reset
REQ-031 While rstn = 1, asynchronously: state IDLE, N = RESET_RATIO, pending ratio cleared, cnt = 0, tc = 0, div_out = 0, cfg_err = 0, busy = 0, settled = 0, settle counter = 0.
REQ-032 Reset asserted mid-PEND SHALL discard the pending ratio; the first cycle after release SHALL present cfg_ready = 1.

Verification
REQ-033 Reset release, en = 1, default params -> cnt 0..7 repeating; tc pulses every 8 cycles; div_out high 4 cycles and low 4; settled rises after the 4th tc.
REQ-034 In RUN with N = 8 and cnt = 3, request ratio 3 -> busy until cnt wraps at 7; new period 0,1,2; div_out pattern 1,0,0; settled clears, then returns after 4 tc.
REQ-035 Request ratio 1 -> cfg_err one-cycle pulse; N, cnt sequence and settled unaffected.
REQ-036 Hold cfg_valid high during PEND -> cfg_ready = 0 until the apply cycle; the second ratio is accepted afterwards and applies at a later tc.
REQ-037 Drop en while in PEND with pending ratio 5 -> IDLE with cnt = 0; after re-enable, period is 5 and tc occurs at cnt = 4.
REQ-038 Assert rstn for 1 ns between clock edges mid-RUN -> all outputs reach their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/div_ratio_ctrl.sv
// Programmable clock divider with a handshaked ratio update. A new ratio that
// arrives while running is held until the next terminal count, so every period is whole.
`timescale 1ns/1ps

module div_ratio_ctrl #(
  parameter int CNT_W       = 4,
  parameter int RESET_RATIO = 8,
  parameter int SETTLE_TC   = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_ratio,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic [CNT_W-1:0] cnt,
  output logic             tc,
  output logic             div_out,
  output logic             busy,
  output logic             settled
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_R   = CNT_W'(2);
  localparam logic [7:0]       SETTLE  = 8'(SETTLE_TC);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       settle_q, settle_d;
  logic             div_q, div_d;
  logic             err_q, err_d;
  logic             tc_w, ready_w, xfer, legal, load;

  assign tc_w    = (state_q != IDLE) && (cnt_q == n_q - ONE);
  assign ready_w = (state_q != PEND);
  assign xfer    = cfg_valid && ready_w;
  assign legal   = (cfg_ratio >= MIN_R);

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    err_d    = xfer && !legal;
    load     = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (xfer && legal) begin
          n_d  = cfg_ratio;
          load = 1'b1;
        end else if (en) begin
          state_d = RUN;
        end
      end
      default: begin
        if (!en) begin
          // Leaving the run states applies whatever ratio is waiting right away.
          state_d = IDLE;
          cnt_d   = '0;
          if (state_q == PEND) begin
            n_d  = pend_q;
            load = 1'b1;
          end else if (xfer && legal) begin
            n_d  = cfg_ratio;
            load = 1'b1;
          end
        end else begin
          cnt_d = tc_w ? '0 : cnt_q + ONE;
          if (tc_w && state_q == PEND) begin
            n_d     = pend_q;
            load    = 1'b1;
            state_d = RUN;
          end
          if (state_q == RUN && xfer && legal) begin
            pend_d  = cfg_ratio;
            state_d = PEND;
          end
        end
      end
    endcase

    if (state_d == IDLE || load)
      settle_d = '0;
    else if (tc_w && settle_q != SETTLE)
      settle_d = settle_q + 8'd1;

    // div_out is registered from next-cycle count and ratio so it lines up with cnt.
    div_d = (state_d != IDLE) && (cnt_d < (n_d >> 1));
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q  <= IDLE;
      n_q      <= CNT_W'(RESET_RATIO);
      pend_q   <= '0;
      cnt_q    <= '0;
      settle_q <= '0;
      div_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      div_q    <= div_d;
      err_q    <= err_d;
    end
  end

  assign cfg_ready = ready_w;
  assign cfg_err   = err_q;
  assign cnt       = cnt_q;
  assign tc        = tc_w;
  assign div_out   = div_q;
  assign busy      = (state_q == PEND);
  assign settled   = (state_q == RUN) && (settle_q == SETTLE);

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Scoreboard bench for div_ratio_ctrl: a behavioural model queues the expected
// outputs for each clock edge and a negedge monitor compares them.
`timescale 1ns/1ps

module tb_div_ratio_ctrl;

  localparam int CNT_W = 4;
  localparam int RR    = 8;
  localparam int STC   = 4;

  logic             clk = 1'b0;
  logic             rstn, en, cfg_valid;
  logic [CNT_W-1:0] cfg_ratio;
  logic             cfg_ready, cfg_err, tc, div_out, busy, settled;
  logic [CNT_W-1:0] cnt;

  div_ratio_ctrl #(.CNT_W(CNT_W), .RESET_RATIO(RR), .SETTLE_TC(STC)) dut (
    .clk(clk), .rstn(rstn), .en(en), .cfg_valid(cfg_valid), .cfg_ratio(cfg_ratio),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .cnt(cnt), .tc(tc),
    .div_out(div_out), .busy(busy), .settled(settled)
  );

  always #5 clk = ~clk;

  typedef enum {M_IDLE, M_RUN, M_PEND} mmode_t;
  typedef struct {
    int c; bit t; bit d; bit b; bit s; bit r; bit e;
  } exp_t;

  mmode_t m_mode;
  int     m_n, m_cnt, m_settle;
  bit     m_err;
  int     m_pend[$];
  exp_t   exp_q[$];

  int checks = 0;
  int errors = 0;

  function automatic void check_output(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_n = RR; m_cnt = 0; m_settle = 0; m_err = 0;
    m_pend.delete();
  endtask

  // One clock edge of the reference behaviour, stated in terms of periods and a pending list.
  task automatic model_step(input bit r, input bit e, input bit v, input int ratio);
    mmode_t old;
    bit tcn, xfer, legal;
    if (r) begin
      model_reset();
      return;
    end
    old   = m_mode;
    tcn   = (old != M_IDLE) && (m_cnt == m_n - 1);
    xfer  = v && (old != M_PEND);
    legal = (ratio >= 2);
    m_err = xfer && !legal;
    if (old == M_IDLE) begin
      if (xfer && legal) begin
        m_n = ratio; m_settle = 0;
      end else if (e) begin
        m_mode = M_RUN; m_cnt = 0;
      end
    end else if (!e) begin
      if (m_pend.size() > 0) m_n = m_pend.pop_front();
      if (old == M_RUN && xfer && legal) m_n = ratio;
      m_mode = M_IDLE; m_cnt = 0; m_settle = 0;
    end else begin
      if (tcn) begin
        m_cnt = 0;
        if (old == M_PEND) begin
          m_n = m_pend.pop_front(); m_settle = 0; m_mode = M_RUN;
        end else if (m_settle < STC) begin
          m_settle++;
        end
      end else begin
        m_cnt++;
      end
      if (old == M_RUN && xfer && legal) begin
        m_pend.push_back(ratio); m_mode = M_PEND;
      end
    end
  endtask

  task automatic push_expected();
    exp_t x;
    x.c = m_cnt;
    x.t = (m_mode != M_IDLE) && (m_cnt == m_n - 1);
    x.d = (m_mode != M_IDLE) && (m_cnt < m_n / 2);
    x.b = (m_pend.size() > 0);
    x.s = (m_mode == M_RUN) && (m_settle == STC);
    x.r = (m_mode != M_PEND);
    x.e = m_err;
    exp_q.push_back(x);
  endtask

  task automatic apply_stimulus(input bit r, input bit e, input bit v, input int ratio);
    @(negedge clk);
    #1;
    rstn = r; en = e; cfg_valid = v; cfg_ratio = CNT_W'(ratio);
    @(posedge clk);
    model_step(r, e, v, ratio);
    push_expected();
  endtask

  task automatic wait_run_cnt(input int want);
    int k;
    for (k = 0; k < 64; k++) begin
      if (m_mode == M_RUN && m_cnt == want) break;
      apply_stimulus(0, 1, 0, 0);
    end
    if (k == 64) check_output("wait_run_cnt_timeout", k, 0);
  endtask

  // Brief reset pulse between edges; outputs must drop without a clock.
  task automatic async_pulse();
    @(negedge clk);
    #1;
    en = 1; cfg_valid = 0;
    #1 rstn = 1;
    #0.5;
    check_output("async_cnt", int'(cnt), 0);
    check_output("async_tc", int'(tc), 0);
    check_output("async_div", int'(div_out), 0);
    check_output("async_busy", int'(busy), 0);
    check_output("async_settled", int'(settled), 0);
    check_output("async_err", int'(cfg_err), 0);
    check_output("async_ready", int'(cfg_ready), 1);
    #0.5 rstn = 0;
    @(posedge clk);
    model_reset();
    model_step(0, 1, 0, 0);
    push_expected();
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      check_output("cnt", int'(cnt), x.c);
      check_output("tc", int'(tc), int'(x.t));
      check_output("div_out", int'(div_out), int'(x.d));
      check_output("busy", int'(busy), int'(x.b));
      check_output("settled", int'(settled), int'(x.s));
      check_output("cfg_ready", int'(cfg_ready), int'(x.r));
      check_output("cfg_err", int'(cfg_err), int'(x.e));
    end
  end

  initial begin
    rstn = 1; en = 0; cfg_valid = 0; cfg_ratio = '0;
    model_reset();
    repeat (3) apply_stimulus(1, 0, 0, 0);

    repeat (40) apply_stimulus(0, 1, 0, 0);

    wait_run_cnt(3);
    apply_stimulus(0, 1, 1, 3);
    repeat (30) apply_stimulus(0, 1, 0, 0);

    apply_stimulus(0, 1, 1, 1);
    repeat (10) apply_stimulus(0, 1, 0, 0);

    wait_run_cnt(0);
    apply_stimulus(0, 1, 1, 5);
    repeat (12) apply_stimulus(0, 1, 1, 6);
    repeat (20) apply_stimulus(0, 1, 0, 0);

    wait_run_cnt(0);
    apply_stimulus(0, 1, 1, 5);
    apply_stimulus(0, 0, 0, 0);
    repeat (20) apply_stimulus(0, 1, 0, 0);

    repeat (3) apply_stimulus(0, 1, 0, 0);
    async_pulse();
    repeat (10) apply_stimulus(0, 1, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      bit r, e, v;
      r = ($urandom_range(0, 199) == 0);
      e = ($urandom_range(0, 15) != 0);
      v = ($urandom_range(0, 5) == 0);
      apply_stimulus(r, e, v, int'($urandom_range(0, 15)));
    end

    @(negedge clk);
    #1;
    check_output("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
